mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single-port 4K x 12 PDP-8 main memory between three requesters: IOT data-break
// (db), front-panel examine/deposit (fp) and the CPU fetch/execute datapath (cpu). Fixed
// priority db > fp > cpu, with a starvation limiter that forces a CPU grant. Sits between the
// CPU/front panel/IOT distributor and the memory model; one access in flight at a time.
// PARAMETERS
// ADDR_W      12  memory address width
// DATA_W      12  memory word width
// RD_LAT      1   memory read latency in cycles after mem_en (legal range 1..7)
// STARVE_LIM  4   consecutive non-CPU grants with cpu_req pending before CPU is forced (>=1)
// PORTS
// clock       in   1       single clock, all state on posedge
// reset       in   1       asynchronous, active-high reset
// X_req       in   1       request, X in {db,fp,cpu}; held high until X_ack
// X_we        in   1       1 = write, 0 = read; stable while X_req high
// X_addr      in   ADDR_W  word address; stable while X_req high
// X_wdata     in   DATA_W  write data; stable while X_req high
// X_ack       out  1       one-cycle completion pulse to requester X
// X_rdata     out  DATA_W  read data to X; valid with X_ack, held until X's next read ack
// mem_en      out  1       one-cycle memory strobe
// mem_we      out  1       write enable, qualified by mem_en
// mem_addr    out  ADDR_W  latched address of granted access
// mem_wdata   out  DATA_W  latched write data of granted access
// mem_rdata   in   DATA_W  memory read data, valid RD_LAT cycles after mem_en
// busy        out  1       high in every state except IDLE
// grant_id    out  2       owner of current access: 0 none, 1 db, 2 fp, 3 cpu
// BEHAVIOUR
// - Reset (async, any state): FSM->IDLE; mem_en, mem_we, all X_ack, busy = 0; grant_id = 0;
//   mem_addr, mem_wdata, all X_rdata = 0; wait and starvation counters = 0. An access
//   in flight is abandoned; a write whose ISSUE edge had not yet occurred is not performed.
// - FSM states: IDLE, ISSUE, WAIT, DONE.
// - IDLE: if any req high, choose winner, latch we/addr/wdata into mem_* regs, set grant_id,
//   busy=1, go ISSUE. No req: stay, grant_id=0.
// - Winner: cpu if cpu_req && starve_cnt==STARVE_LIM; else db, then fp, then cpu.
// - ISSUE (1 cycle): mem_en=1. Write -> DONE. Read -> WAIT, load wait counter RD_LAT-1.
// - WAIT: counter decrements each cycle; at 0, capture mem_rdata into X_rdata, go DONE.
//   Capture is exactly RD_LAT cycles after the mem_en cycle.
// - DONE (1 cycle): X_ack=1 for the owner only; next state IDLE. Requests are not sampled
//   in DONE, so a requester may drop req in the ack cycle or the cycle after.
// - Latency req->ack (arbiter idle): write 3 cycles, read 3+RD_LAT cycles. No pipelining.
// - Starvation: at each IDLE grant, if cpu_req high and winner != cpu, starve_cnt++
//   (saturates at STARVE_LIM); cleared on a CPU grant or any IDLE cycle with cpu_req low.
// - Simultaneous requests: only one granted; losers keep req high and are re-arbitrated
//   in the IDLE cycle following DONE.
// - Protocol violation (req dropped before ack, or we/addr/wdata changed): access still
//   completes from latched values and ack still pulses; bench assertion flags it.
// - Addresses are used as-is; no wrap/increment logic (auto-index is the CPU's job).
// - mem_we/mem_addr/mem_wdata hold their last values outside ISSUE.
// TESTING
// - Reset: assert reset mid-WAIT of cpu read -> next cycle mem_en=0, busy=0, grant_id=0,
//   no cpu_ack ever issued for that access; post-reset cpu read of 12'o0200 completes.
// - Single cpu write 12'o7777 to 12'o0020 then read (RD_LAT=1) -> mem_en at cycles 2 and
//   5 after first req, cpu_ack at cycle 3 and 7, cpu_rdata=12'o7777.
// - db, fp, cpu raise req same cycle -> grant order db, fp, cpu; grant_id 1,2,3; one ack each.
// - db and fp requesting continuously, cpu_req held, STARVE_LIM=4 -> cpu granted as 5th
//   access, then counter clears and db wins next.
// - RD_LAT=3 sweep -> read ack exactly 6 cycles after req; fp_rdata held across later cpu write.
// - Requester drops req during WAIT -> access completes, ack pulses once, assertion fires.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port PDP-8 main memory arbiter: data-break > front panel > CPU, with a
// starvation limiter that forces a CPU grant. One access in flight at a time.
module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 12,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              db_req,
    input  logic              db_we,
    input  logic [ADDR_W-1:0] db_addr,
    input  logic [DATA_W-1:0] db_wdata,
    output logic              db_ack,
    output logic [DATA_W-1:0] db_rdata,
    input  logic              fp_req,
    input  logic              fp_we,
    input  logic [ADDR_W-1:0] fp_addr,
    input  logic [DATA_W-1:0] fp_wdata,
    output logic              fp_ack,
    output logic [DATA_W-1:0] fp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_DB   = 2'd1;
    localparam logic [1:0] GNT_FP   = 2'd2;
    localparam logic [1:0] GNT_CPU  = 2'd3;

    localparam int              SC_W       = $clog2(STARVE_LIM + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);
    localparam logic [2:0]      WAIT_LOAD  = 3'(RD_LAT - 1);

    state_t            state, next_state;
    logic [1:0]        winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [SC_W-1:0]   starve_cnt;
    logic [2:0]        wait_cnt;

    // Arbitration: a saturated starvation count overrides the fixed priority.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
        winner    = GNT_NONE;
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (cpu_req && starve_cnt == STARVE_MAX) winner = GNT_CPU;
        else if (db_req)                         winner = GNT_DB;
        else if (fp_req)                         winner = GNT_FP;
        else if (cpu_req)                        winner = GNT_CPU;
        case (winner)
            GNT_DB: begin
                sel_we    = db_we;
                sel_addr  = db_addr;
                sel_wdata = db_wdata;
            end
            GNT_FP: begin
                sel_we    = fp_we;
                sel_addr  = fp_addr;
                sel_wdata = fp_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_en     = 1'b0;
        busy       = (state != IDLE);
        db_ack     = 1'b0;
        fp_ack     = 1'b0;
        cpu_ack    = 1'b0;
        case (state)
            IDLE:  if (winner != GNT_NONE) next_state = ISSUE;
            ISSUE: begin
                mem_en     = 1'b1;
                next_state = mem_we ? DONE : WAIT;
            end
            WAIT:  if (wait_cnt == 3'd0) next_state = DONE;
            DONE: begin
                db_ack     = (grant_id == GNT_DB);
                fp_ack     = (grant_id == GNT_FP);
                cpu_ack    = (grant_id == GNT_CPU);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Latched access, owner, counters and per-requester read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            grant_id   <= GNT_NONE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            db_rdata   <= '0;
            fp_rdata   <= '0;
            cpu_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (winner != GNT_NONE) begin
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        grant_id  <= winner;
                    end
                    // A pending CPU request implies a winner, so this covers only real grants.
                    if (!cpu_req || winner == GNT_CPU) starve_cnt <= '0;
                    else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
                end
                ISSUE: wait_cnt <= WAIT_LOAD;
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        case (grant_id)
                            GNT_DB:  db_rdata  <= mem_rdata;
                            GNT_FP:  fp_rdata  <= mem_rdata;
                            GNT_CPU: cpu_rdata <= mem_rdata;
                            default: ;
                        endcase
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: grant_id <= GNT_NONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// each backed by a small behavioural memory with the matching read latency.
module tb_mem_port_arbiter;

    localparam int RL1 = 1;
    localparam int RL3 = 3;

    logic clock, reset;

    logic        db_req, db_we, fp_req, fp_we, cpu_req, cpu_we;
    logic [11:0] db_addr, db_wdata, fp_addr, fp_wdata, cpu_addr, cpu_wdata;
    logic        db_ack, fp_ack, cpu_ack;
    logic [11:0] db_rdata, fp_rdata, cpu_rdata;
    logic        mem_en, mem_we, busy;
    logic [11:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant_id;

    logic        l3_db_req, l3_db_we, l3_fp_req, l3_fp_we, l3_cpu_req, l3_cpu_we;
    logic [11:0] l3_db_addr, l3_db_wdata, l3_fp_addr, l3_fp_wdata, l3_cpu_addr, l3_cpu_wdata;
    logic        l3_db_ack, l3_fp_ack, l3_cpu_ack;
    logic [11:0] l3_db_rdata, l3_fp_rdata, l3_cpu_rdata;
    logic        l3_mem_en, l3_mem_we, l3_busy;
    logic [11:0] l3_mem_addr, l3_mem_wdata, l3_mem_rdata;
    logic [1:0]  l3_grant_id;

    int checks = 0;
    int errors = 0;
    int db_acks = 0, fp_acks = 0, cpu_acks = 0, viol_cnt = 0;
    logic [1:0] ack_log[$];

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(12), .RD_LAT(RL1), .STARVE_LIM(4)) dut (
        .clock(clock), .reset(reset),
        .db_req(db_req), .db_we(db_we), .db_addr(db_addr), .db_wdata(db_wdata),
        .db_ack(db_ack), .db_rdata(db_rdata),
        .fp_req(fp_req), .fp_we(fp_we), .fp_addr(fp_addr), .fp_wdata(fp_wdata),
        .fp_ack(fp_ack), .fp_rdata(fp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(12), .RD_LAT(RL3), .STARVE_LIM(4)) dut_l3 (
        .clock(clock), .reset(reset),
        .db_req(l3_db_req), .db_we(l3_db_we), .db_addr(l3_db_addr), .db_wdata(l3_db_wdata),
        .db_ack(l3_db_ack), .db_rdata(l3_db_rdata),
        .fp_req(l3_fp_req), .fp_we(l3_fp_we), .fp_addr(l3_fp_addr), .fp_wdata(l3_fp_wdata),
        .fp_ack(l3_fp_ack), .fp_rdata(l3_fp_rdata),
        .cpu_req(l3_cpu_req), .cpu_we(l3_cpu_we), .cpu_addr(l3_cpu_addr),
        .cpu_wdata(l3_cpu_wdata), .cpu_ack(l3_cpu_ack), .cpu_rdata(l3_cpu_rdata),
        .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
        .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata), .busy(l3_busy),
        .grant_id(l3_grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory models: read data is visible exactly RL cycles after the mem_en cycle, junk otherwise.
    logic [11:0]    mem1 [4096];
    logic [11:0]    pipe1 [RL1];
    logic [RL1-1:0] vld1;
    logic [11:0]    mem3 [4096];
    logic [11:0]    pipe3 [RL3];
    logic [RL3-1:0] vld3;

    always @(posedge clock) begin
        if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
        pipe1[0] <= mem1[mem_addr];
        vld1[0]  <= mem_en && !mem_we;
        for (int i = 1; i < RL1; i++) begin
            pipe1[i] <= pipe1[i-1];
            vld1[i]  <= vld1[i-1];
        end
        if (l3_mem_en && l3_mem_we) mem3[l3_mem_addr] <= l3_mem_wdata;
        pipe3[0] <= mem3[l3_mem_addr];
        vld3[0]  <= l3_mem_en && !l3_mem_we;
        for (int j = 1; j < RL3; j++) begin
            pipe3[j] <= pipe3[j-1];
            vld3[j]  <= vld3[j-1];
        end
    end

    assign mem_rdata    = vld1[RL1-1] ? pipe1[RL1-1] : 12'hbad;
    assign l3_mem_rdata = vld3[RL3-1] ? pipe3[RL3-1] : 12'hbad;

    // Ack counters and protocol monitor: an owner must hold req/we/addr/wdata until its ack.
    logic [25:0] prev_db, prev_fp, prev_cpu;
    always @(negedge clock) begin
        if (db_ack)  db_acks++;
        if (fp_ack)  fp_acks++;
        if (cpu_ack) cpu_acks++;
        if (grant_id == 2'd1 && !db_ack && {db_req, db_we, db_addr, db_wdata} != prev_db)
            viol_cnt++;
        if (grant_id == 2'd2 && !fp_ack && {fp_req, fp_we, fp_addr, fp_wdata} != prev_fp)
            viol_cnt++;
        if (grant_id == 2'd3 && !cpu_ack && {cpu_req, cpu_we, cpu_addr, cpu_wdata} != prev_cpu)
            viol_cnt++;
        prev_db  = {db_req, db_we, db_addr, db_wdata};
        prev_fp  = {fp_req, fp_we, fp_addr, fp_wdata};
        prev_cpu = {cpu_req, cpu_we, cpu_addr, cpu_wdata};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Collect n acks from the RD_LAT=1 instance, dropping req on ack for ports in drop
    // ({cpu,fp,db}); all requests are released in the final ack cycle.
    task automatic wait_acks(input string tag, input int n, input logic [2:0] drop,
                             input int budget);
        int got = 0;
        int cyc = 0;
        ack_log.delete();
        while (got < n && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (db_ack || fp_ack || cpu_ack) begin
                ack_log.push_back(grant_id);
                if (db_ack && drop[0])  db_req  = 1'b0;
                if (fp_ack && drop[1])  fp_req  = 1'b0;
                if (cpu_ack && drop[2]) cpu_req = 1'b0;
                got++;
            end
        end
        db_req  = 1'b0;
        fp_req  = 1'b0;
        cpu_req = 1'b0;
        check({tag, "_ack_count"}, got, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        logic [1:0] starve_exp [6];

        for (int k = 0; k < 4096; k++) begin
            mem1[k] = 12'o0000;
            mem3[k] = 12'o0000;
        end
        mem1[12'o0200] = 12'o3456;
        mem1[12'o0040] = 12'o0707;
        mem3[12'o0100] = 12'o1234;

        reset = 1'b1;
        {db_req, db_we, fp_req, fp_we, cpu_req, cpu_we} = '0;
        {db_addr, db_wdata, fp_addr, fp_wdata, cpu_addr, cpu_wdata} = '0;
        {l3_db_req, l3_db_we, l3_fp_req, l3_fp_we, l3_cpu_req, l3_cpu_we} = '0;
        {l3_db_addr, l3_db_wdata, l3_fp_addr, l3_fp_wdata, l3_cpu_addr, l3_cpu_wdata} = '0;

        // Reset state.
        @(negedge clock);
        check("rst_mem_en",    mem_en,    0);
        check("rst_busy",      busy,      0);
        check("rst_grant",     grant_id,  0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_l3_busy",   l3_busy,   0);
        step();
        reset = 1'b0;

        // Reset in the middle of a CPU read abandons it; the held request then completes.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'o0200;
        step();
        step();
        check("midrst_pre_busy", busy, 1);
        #2 reset = 1'b1;
        @(negedge clock);
        check("midrst_mem_en", mem_en,   0);
        check("midrst_busy",   busy,     0);
        check("midrst_grant",  grant_id, 0);
        step();
        check("midrst_no_ack", cpu_acks, 0);
        reset = 1'b0;
        wait_acks("postrst", 1, 3'b111, 20);
        check("postrst_rdata", cpu_rdata, 12'o3456);
        step();
        check("postrst_acks", cpu_acks, 1);

        // CPU write then read at RD_LAT=1; cycle 1 is the first cycle req is seen in IDLE.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'o0020; cpu_wdata = 12'o7777;
        @(negedge clock);
        check("wr_c1_mem_en", mem_en, 0);
        step(); @(negedge clock);
        check("wr_c2_mem_en",    mem_en,    1);
        check("wr_c2_mem_we",    mem_we,    1);
        check("wr_c2_mem_addr",  mem_addr,  12'o0020);
        check("wr_c2_mem_wdata", mem_wdata, 12'o7777);
        check("wr_c2_grant",     grant_id,  3);
        step(); @(negedge clock);
        check("wr_c3_ack", cpu_ack, 1);
        step();
        cpu_we = 1'b0;
        @(negedge clock);
        check("rd_c4_ack",    cpu_ack, 0);
        check("rd_c4_mem_en", mem_en,  0);
        step(); @(negedge clock);
        check("rd_c5_mem_en", mem_en, 1);
        check("rd_c5_mem_we", mem_we, 0);
        step(); @(negedge clock);
        check("rd_c6_ack",  cpu_ack, 0);
        check("rd_c6_busy", busy,    1);
        step(); @(negedge clock);
        check("rd_c7_ack",   cpu_ack,   1);
        check("rd_c7_rdata", cpu_rdata, 12'o7777);
        step();
        cpu_req = 1'b0;

        // Simultaneous requests: served db, fp, cpu with exactly one ack each.
        step();
        a0 = db_acks; a1 = fp_acks; a2 = cpu_acks;
        db_req  = 1'b1; db_we  = 1'b1; db_addr  = 12'o0030; db_wdata  = 12'o1111;
        fp_req  = 1'b1; fp_we  = 1'b0; fp_addr  = 12'o0020;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'o0031; cpu_wdata = 12'o2222;
        wait_acks("simul", 3, 3'b111, 60);
        check("simul_first",  ack_log.size() > 0 ? ack_log[0] : 2'd0, 1);
        check("simul_second", ack_log.size() > 1 ? ack_log[1] : 2'd0, 2);
        check("simul_third",  ack_log.size() > 2 ? ack_log[2] : 2'd0, 3);
        check("simul_fp_rdata", fp_rdata, 12'o7777);
        step();
        check("simul_db_once",  db_acks  - a0, 1);
        check("simul_fp_once",  fp_acks  - a1, 1);
        check("simul_cpu_once", cpu_acks - a2, 1);

        // Starvation: db and fp never let go; the CPU wins the fifth grant, db the sixth.
        step();
        starve_exp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd1};
        db_req  = 1'b1; db_we  = 1'b1; db_addr  = 12'o0050; db_wdata  = 12'o0001;
        fp_req  = 1'b1; fp_we  = 1'b1; fp_addr  = 12'o0051; fp_wdata  = 12'o0002;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'o0052; cpu_wdata = 12'o0003;
        wait_acks("starve", 6, 3'b100, 200);
        for (int g = 0; g < 6; g++)
            check($sformatf("starve_grant%0d", g + 1),
                  ack_log.size() > g ? ack_log[g] : 2'd0, starve_exp[g]);
        check("starve_mem", mem1[12'o0052], 12'o0003);
        step();
        check("no_viol_yet", viol_cnt, 0);

        // RD_LAT=3: fp read acks in cycle 6; its data survives a later CPU write.
        step();
        l3_fp_req = 1'b1; l3_fp_we = 1'b0; l3_fp_addr = 12'o0100;
        @(negedge clock);
        check("l3_c1_ack", l3_fp_ack, 0);
        for (int c = 2; c <= 6; c++) begin
            step(); @(negedge clock);
            check($sformatf("l3_c%0d_ack", c), l3_fp_ack, (c == 6) ? 1 : 0);
            if (c == 2) check("l3_c2_mem_en", l3_mem_en, 1);
        end
        check("l3_fp_rdata", l3_fp_rdata, 12'o1234);
        step();
        l3_fp_req  = 1'b0;
        l3_cpu_req = 1'b1; l3_cpu_we = 1'b1; l3_cpu_addr = 12'o0100; l3_cpu_wdata = 12'o4321;
        step(); step(); @(negedge clock);
        check("l3_wr_ack", l3_cpu_ack, 1);
        step();
        l3_cpu_we = 1'b0;
        check("l3_fp_rdata_held",  l3_fp_rdata,  12'o1234);
        check("l3_cpu_rdata_idle", l3_cpu_rdata, 12'o0000);
        for (int c = 2; c <= 6; c++) begin
            step(); @(negedge clock);
        end
        check("l3_rd_ack",   l3_cpu_ack,   1);
        check("l3_rd_rdata", l3_cpu_rdata, 12'o4321);
        step();
        l3_cpu_req = 1'b0;

        // Request dropped during WAIT: access still completes, one ack, monitor notices.
        step();
        a0 = db_acks;
        db_req = 1'b1; db_we = 1'b0; db_addr = 12'o0040;
        step();
        step();
        db_req = 1'b0;
        @(negedge clock);
        check("drop_c3_ack", db_ack, 0);
        step(); @(negedge clock);
        check("drop_c4_ack",   db_ack,   1);
        check("drop_c4_rdata", db_rdata, 12'o0707);
        repeat (3) step();
        check("drop_ack_once", db_acks - a0, 1);
        check("drop_idle",     busy,         0);
        check("drop_viol",     viol_cnt,     1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
